task_sched_tdm: RTL and testbench
=================================

Name: task_sched_tdm

Overview:
- Parametrised time-division task scheduler, the successor to the fixed 4-task manager.
- Walks a programmable schedule table of task IDs and gives each slot to one task for a per-task budget of ticks.
- Publishes the active task and its remaining ticks to the dispatch logic.
- Adds over the previous generation: runtime table/budget programming, end-of-frame marker, enable/hold, slot skip, status pulses.

Parameters:
- NUM_TASKS, 4: number of tasks; must be <= 2^TASK_W - 1.
- TASK_W, 4: task ID width. END_ID = 2^TASK_W - 1 is the end-of-frame marker.
- TIME_W, 4: budget/timer width; must be >= TASK_W.
- TABLE_DEPTH, 16: schedule table entries.
- IDX_W, 4: table index width; equals clog2(TABLE_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  run enable; low = hold
- skip  in  1  end current slot early
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = schedule table, 1 = budget table
- cfg_addr  in  IDX_W  table index or task ID
- cfg_data  in  TIME_W  task ID (low TASK_W bits) or budget
- cfg_err  out  1  1-cycle pulse on a rejected write
- task_no  out  TASK_W  active task
- timer_left  out  TIME_W  remaining ticks in the slot
- task_valid  out  1  task_no is a scheduled task
- slot_start  out  1  pulse on the first cycle of each slot
- frame_wrap  out  1  pulse when a slot starts at index 0 after a wrap
- entry_index  out  IDX_W  current table index

Behaviour:

Reset:
- Effect: state IDLE; all outputs 0.
- sched[i] = i mod NUM_TASKS; budget[t] = t+1.
- rst has priority over everything and takes effect mid-slot at the next edge.

States:
- IDLE: taken after reset. Leaves on the first cycle en=1.
  - sched[0] != END_ID: load entry 0 and go to RUN.
  - otherwise: go to EMPTY.
- Load (same edge, no dead cycle):
  - task_no <= sched[idx]
  - timer_left <= budget[sched[idx]]
  - entry_index <= idx
  - task_valid <= 1
  - slot_start <= 1
- RUN, en=1:
  - timer_left > 0 and skip=0: decrement.
  - timer_left == 0 or skip=1: advance.
  - A slot with budget B therefore lasts B+1 cycles; budget 0 lasts 1 cycle.
- Advance:
  - nxt = entry_index+1.
  - If nxt == TABLE_DEPTH or sched[nxt] == END_ID: nxt = 0 and frame_wrap <= 1 with the load.
  - If the wrapped sched[0] == END_ID: go to EMPTY.
  - Otherwise load nxt.
- RUN, en=0: freeze all state; pulses 0; skip ignored.
- EMPTY: task_valid=0, task_no=0, timer_left=0, entry_index=0, no pulses. Re-checks sched[0] each cycle en=1 and loads entry 0 once it is valid (slot_start=1, frame_wrap=0).

Config writes (any state, any en):
- cfg_sel=0: cfg_addr < TABLE_DEPTH required. Data must be < NUM_TASKS or equal to END_ID; otherwise ignored with cfg_err.
- cfg_sel=1: cfg_addr < NUM_TASKS required; otherwise ignored with cfg_err.
- A load in the same cycle as a write to the same location reads the old value (read-before-write).
- A budget write never alters the running timer_left; it applies at that task's next load.
- Writing END_ID to an entry ahead of the current index truncates the current frame.

Widths and timing:
- Arithmetic is unsigned with no wrap; timer_left never underflows.
- Index compare happens at IDX_W+1 bits.
- All outputs are registered.

Test Plan:
1. Reset, en=1 from cycle 0. Cycle 1: slot_start, task_no=0, timer_left=1, index 0. Cycle 2: timer 0. Cycle 3: slot_start, task 1, timer 2. At index 15→0: frame_wrap=1, task 0.
2. Write sched[3]=15 (END_ID), then run. Frame is 0,1,2; after task 2's 4-cycle slot, frame_wrap=1, task_no=0, entry_index=0. Slot lengths are 2, 3, 4 cycles.
3. Write budget[1]=0. Task 1 slot lasts exactly 1 cycle with timer_left=0; next cycle task 2, timer 3.
4. Assert skip while task 2 timer_left=2. Next cycle: task 3, timer 4, slot_start=1. Repeat with en=0: skip ignored, outputs frozen for 5 cycles.
5. Write sched[0]=15 while idle, assert en. Required: EMPTY with task_valid=0. Then write sched[0]=2: next cycle task_no=2, timer 3, slot_start=1.
6. Write sched data 7 (NUM_TASKS=4) and budget addr 5: cfg_err pulses twice, tables unchanged. Assert rst mid-slot: all outputs 0 next cycle and tables restored to reset contents.

Source files
------------

// File: rtl/task_sched_tdm.sv
// Time-division task scheduler: walks a programmable schedule table and grants
// each slot to one task for its programmed budget of ticks.
module task_sched_tdm #(
  parameter int NUM_TASKS   = 4,
  parameter int TASK_W      = 4,
  parameter int TIME_W      = 4,
  parameter int TABLE_DEPTH = 16,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              skip,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [TIME_W-1:0] cfg_data,
  output logic              cfg_err,
  output logic [TASK_W-1:0] task_no,
  output logic [TIME_W-1:0] timer_left,
  output logic              task_valid,
  output logic              slot_start,
  output logic              frame_wrap,
  output logic [IDX_W-1:0]  entry_index
);

  localparam logic [TASK_W-1:0] END_ID  = '1;
  localparam int                NUM_IDS = 2**TASK_W;

  typedef enum logic [1:0] {IDLE, RUN, EMPTY} state_t;

  state_t state_reg, state_next;

  // Budget table spans the full task-ID space so any ID indexes it safely;
  // entries at or above NUM_TASKS stay zero and are never written.
  logic [TASK_W-1:0] sched_reg  [TABLE_DEPTH];
  logic [TIME_W-1:0] budget_reg [NUM_IDS];

  logic [TASK_W-1:0] task_reg, task_next;
  logic [TIME_W-1:0] timer_reg, timer_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              valid_reg, valid_next;
  logic              start_reg, start_next;
  logic              wrap_reg, wrap_next;
  logic              err_reg, err_next;

  logic [TASK_W-1:0]      cfg_id;
  logic                   sched_ok, budget_ok;
  logic [TABLE_DEPTH-1:0] sched_we;
  logic [NUM_IDS-1:0]     budget_we;

  assign cfg_id    = cfg_data[TASK_W-1:0];
  assign sched_ok  = (int'(cfg_addr) < TABLE_DEPTH) &&
                     ((int'(cfg_id) < NUM_TASKS) || (cfg_id == END_ID));
  assign budget_ok = int'(cfg_addr) < NUM_TASKS;
  assign err_next  = cfg_we && (cfg_sel ? !budget_ok : !sched_ok);

  generate
    for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_sched_we
      assign sched_we[gi] = cfg_we && !cfg_sel && sched_ok && (int'(cfg_addr) == gi);
    end
    for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_budget_we
      assign budget_we[gi] = cfg_we && cfg_sel && budget_ok && (int'(cfg_addr) == gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (rst)              sched_reg[i] <= TASK_W'(i % NUM_TASKS);
      else if (sched_we[i]) sched_reg[i] <= cfg_id;
    end
    for (int i = 0; i < NUM_IDS; i++) begin
      if (rst)               budget_reg[i] <= (i < NUM_TASKS) ? TIME_W'(i + 1) : '0;
      else if (budget_we[i]) budget_reg[i] <= cfg_data;
    end
  end

  // Candidate entry for a load: the following table slot while running,
  // entry 0 on a wrap or when starting from IDLE/EMPTY.
  logic [IDX_W:0]    nxt_wide;
  logic              wrap;
  logic [IDX_W-1:0]  load_idx;
  logic [TASK_W-1:0] load_id;

  always_comb begin
    nxt_wide = {1'b0, idx_reg} + (IDX_W+1)'(1);
    wrap     = (int'(nxt_wide) == TABLE_DEPTH) || (sched_reg[nxt_wide[IDX_W-1:0]] == END_ID);
    load_idx = '0;
    if (state_reg == RUN && !wrap) load_idx = nxt_wide[IDX_W-1:0];
    load_id  = sched_reg[load_idx];
  end

  always_comb begin
    state_next = state_reg;
    task_next  = task_reg;
    timer_next = timer_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    start_next = 1'b0;
    wrap_next  = 1'b0;
    if (en) begin
      if (state_reg == RUN && timer_reg != '0 && !skip) begin
        timer_next = timer_reg - TIME_W'(1);
      end else if (load_id == END_ID) begin
        state_next = EMPTY;
        task_next  = '0;
        timer_next = '0;
        idx_next   = '0;
        valid_next = 1'b0;
      end else begin
        state_next = RUN;
        task_next  = load_id;
        timer_next = budget_reg[load_id];
        idx_next   = load_idx;
        valid_next = 1'b1;
        start_next = 1'b1;
        wrap_next  = (state_reg == RUN) && wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      task_reg  <= '0;
      timer_reg <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      start_reg <= 1'b0;
      wrap_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      task_reg  <= task_next;
      timer_reg <= timer_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      start_reg <= start_next;
      wrap_reg  <= wrap_next;
      err_reg   <= err_next;
    end
  end

  assign cfg_err     = err_reg;
  assign task_no     = task_reg;
  assign timer_left  = timer_reg;
  assign task_valid  = valid_reg;
  assign slot_start  = start_reg;
  assign frame_wrap  = wrap_reg;
  assign entry_index = idx_reg;

endmodule

// File: tb/tb_task_sched_tdm.sv
// Bench for task_sched_tdm: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a slot-level reference model.
module tb_task_sched_tdm;

  localparam int NUM_TASKS   = 4;
  localparam int TASK_W      = 4;
  localparam int TIME_W      = 4;
  localparam int TABLE_DEPTH = 16;
  localparam int IDX_W       = 4;
  localparam int END_ID      = 15;

  logic              clk = 1'b0;
  logic              rst, en, skip, cfg_we, cfg_sel;
  logic [IDX_W-1:0]  cfg_addr;
  logic [TIME_W-1:0] cfg_data;
  logic              cfg_err, task_valid, slot_start, frame_wrap;
  logic [TASK_W-1:0] task_no;
  logic [TIME_W-1:0] timer_left;
  logic [IDX_W-1:0]  entry_index;

  task_sched_tdm #(
    .NUM_TASKS(NUM_TASKS), .TASK_W(TASK_W), .TIME_W(TIME_W),
    .TABLE_DEPTH(TABLE_DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .skip(skip),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .task_no(task_no), .timer_left(timer_left),
    .task_valid(task_valid), .slot_start(slot_start), .frame_wrap(frame_wrap),
    .entry_index(entry_index)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a slot is described by its table entry, its task, its
  // length in ticks and how many ticks have elapsed; timer_left = len - elapsed.
  int m_sched [TABLE_DEPTH];
  int m_budget[NUM_TASKS];
  int m_mode;   // 0 idle, 1 running a slot, 2 empty frame
  int m_idx, m_task, m_len, m_elapsed;
  bit m_start, m_wrap, m_err;

  function automatic void begin_slot(int i);
    m_mode    = 1;
    m_idx     = i;
    m_task    = m_sched[i];
    m_len     = m_budget[m_task];
    m_elapsed = 0;
    m_start   = 1;
  endfunction

  function automatic void model_step(bit r, bit e, bit s, bit we, bit sel, int addr, int data);
    int n;
    if (r) begin
      for (int i = 0; i < TABLE_DEPTH; i++) m_sched[i] = i % NUM_TASKS;
      for (int t = 0; t < NUM_TASKS; t++)   m_budget[t] = t + 1;
      m_mode = 0; m_idx = 0; m_task = 0; m_len = 0; m_elapsed = 0;
      m_start = 0; m_wrap = 0; m_err = 0;
      return;
    end
    m_start = 0;
    m_wrap  = 0;
    if (e) begin
      if (m_mode != 1) begin
        if (m_sched[0] != END_ID) begin_slot(0);
        else m_mode = 2;
      end else if (m_elapsed < m_len && !s) begin
        m_elapsed++;
      end else begin
        n = m_idx + 1;
        if (n >= TABLE_DEPTH || m_sched[n] == END_ID) begin
          if (m_sched[0] == END_ID) m_mode = 2;
          else begin
            begin_slot(0);
            m_wrap = 1;
          end
        end else begin
          begin_slot(n);
        end
      end
    end
    // Table updates land after any load this cycle, which sees old contents.
    m_err = 0;
    if (we) begin
      if (!sel) begin
        if (addr < TABLE_DEPTH && (data < NUM_TASKS || data == END_ID)) m_sched[addr] = data;
        else m_err = 1;
      end else begin
        if (addr < NUM_TASKS) m_budget[addr] = data;
        else m_err = 1;
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("task_valid",  int'(task_valid),  (m_mode == 1) ? 1 : 0);
      chk("task_no",     int'(task_no),     (m_mode == 1) ? m_task : 0);
      chk("timer_left",  int'(timer_left),  (m_mode == 1) ? (m_len - m_elapsed) : 0);
      chk("entry_index", int'(entry_index), (m_mode == 1) ? m_idx : 0);
      chk("slot_start",  int'(slot_start),  int'(m_start));
      chk("frame_wrap",  int'(frame_wrap),  int'(m_wrap));
      chk("cfg_err",     int'(cfg_err),     int'(m_err));
    end
  end

  // Drive one cycle of inputs at a falling edge and return at the next one.
  task automatic cycle(bit r, bit e, bit s, bit we, bit sel, int addr, int data);
    rst      = r;
    en       = e;
    skip     = s;
    cfg_we   = we;
    cfg_sel  = sel;
    cfg_addr = IDX_W'(addr);
    cfg_data = TIME_W'(data);
    model_step(r, e, s, we, sel, addr, data);
    @(negedge clk);
    if (we) $display("cfg write sel=%0d addr=%0d data=%0d err=%0d", sel, addr, data, cfg_err);
  endtask

  task automatic expect_out(string tag, int tno, int tl, int v, int st, int fw, int idx);
    chk({tag, ".task_no"},     int'(task_no),     tno);
    chk({tag, ".timer_left"},  int'(timer_left),  tl);
    chk({tag, ".task_valid"},  int'(task_valid),  v);
    chk({tag, ".slot_start"},  int'(slot_start),  st);
    chk({tag, ".frame_wrap"},  int'(frame_wrap),  fw);
    chk({tag, ".entry_index"}, int'(entry_index), idx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; skip = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
    cfg_addr = '0; cfg_data = '0;
    @(negedge clk);

    // Default schedule from reset, wrap after 16 entries
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk_on = 1;
    cycle(1, 0, 0, 0, 0, 0, 0);
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.cfg_err", int'(cfg_err), 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t1.c1", 0, 1, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t1.c2", 0, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t1.c3", 1, 2, 1, 1, 0, 1);
    repeat (54) cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t1.wrap", 0, 1, 1, 1, 1, 0);
    $display("step 1 done");

    // END_ID at entry 3 truncates the frame to 0,1,2
    cycle(1, 0, 0, 0, 0, 0, 0);
    expect_out("t2.rst", 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 3, END_ID);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t2.s0", 0, 1, 1, 1, 0, 0);
    repeat (2) cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t2.s1", 1, 2, 1, 1, 0, 1);
    repeat (3) cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t2.s2", 2, 3, 1, 1, 0, 2);
    repeat (4) cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t2.wrap", 0, 1, 1, 1, 1, 0);
    $display("step 2 done");

    // Zero budget gives a single-cycle slot
    cycle(0, 0, 0, 1, 1, 1, 0);
    expect_out("t3.hold", 0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t3.t0", 0, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t3.b0", 1, 0, 1, 1, 0, 1);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t3.next", 2, 3, 1, 1, 0, 2);
    $display("step 3 done");

    // Skip ends a slot early; skip under en=0 is ignored
    cycle(0, 0, 0, 1, 0, 3, 3);
    expect_out("t4.hold", 2, 3, 1, 0, 0, 2);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t4.t2", 2, 2, 1, 0, 0, 2);
    cycle(0, 1, 1, 0, 0, 0, 0);
    expect_out("t4.skip", 3, 4, 1, 1, 0, 3);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 1, 0, 0, 0, 0);
      expect_out("t4.frozen", 3, 4, 1, 0, 0, 3);
    end
    $display("step 4 done");

    // Empty schedule, then recovery once entry 0 becomes valid
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, END_ID);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t5.empty", 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t5.empty2", 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 2);
    expect_out("t5.write", 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t5.load", 2, 3, 1, 1, 0, 0);
    $display("step 5 done");

    // Rejected writes and mid-slot reset
    cycle(0, 1, 0, 1, 0, 5, 7);
    chk("t6.err_sched", int'(cfg_err), 1);
    cycle(0, 1, 0, 1, 1, 5, 9);
    chk("t6.err_budget", int'(cfg_err), 1);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("t6.err_clear", int'(cfg_err), 0);
    expect_out("t6.run", 2, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    expect_out("t6.rst", 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t6.restored0", 0, 1, 1, 1, 0, 0);
    repeat (2) cycle(0, 1, 0, 0, 0, 0, 0);
    expect_out("t6.restored1", 1, 2, 1, 1, 0, 1);
    $display("step 6 done");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit r, e, s, we, sel;
      int addr, data;
      r    = ($urandom_range(0, 299) == 0);
      e    = ($urandom_range(0, 99) < 85);
      s    = ($urandom_range(0, 99) < 8);
      we   = ($urandom_range(0, 99) < 10);
      sel  = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 15);
      data = $urandom_range(0, 15);
      if (we && !sel && $urandom_range(0, 1) == 1) data = $urandom_range(0, NUM_TASKS - 1);
      cycle(r, e, s, we, sel, addr, data);
    end

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
